ssd_scan_n: RTL and testbench

SSD_SCAN_N -- requirements
Module: ssd_scan_n

---
 rtl/ssd_pkg.sv | 23 ++
 rtl/ssd_scan_timer.sv | 73 +++++++
 rtl/ssd_scan_n.sv | 111 +++++++++++
 tb/tb_ssd_scan_n.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: drive levels,
// segment bit positions within a digit field, and the default slot length.
package ssd_pkg;

    localparam logic SegOn = 1'b0;
    localparam logic AnOn  = 1'b0;

    localparam int unsigned SegW = 7;

    // Position of each segment inside a 7-bit digit field (a is the MSB).
    localparam int unsigned SegIdxA = 6;
    localparam int unsigned SegIdxB = 5;
    localparam int unsigned SegIdxC = 4;
    localparam int unsigned SegIdxD = 3;
    localparam int unsigned SegIdxE = 2;
    localparam int unsigned SegIdxF = 1;
    localparam int unsigned SegIdxG = 0;

    localparam int unsigned ScanDivDefault = 25000;

    typedef logic [SegW-1:0] seg_t;

endpackage

// File: rtl/ssd_scan_timer.sv
// Scan timing: slot counter, digit index, blink frame counter and blink phase.
// Exports the brightness sub-interval index and an end-of-frame strobe.
module ssd_scan_timer import ssd_pkg::*; #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = ScanDivDefault,
    parameter int unsigned BRIGHT_W     = 3,
    parameter int unsigned BLINK_FRAMES = 64,
    localparam int unsigned CntW = $clog2(SCAN_DIV),
    localparam int unsigned DigW = $clog2(NUM_DIGITS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic [CntW-1:0]     cnt_o,
    output logic [DigW-1:0]     dig_o,
    output logic [BRIGHT_W-1:0] sub_o,
    output logic                phase_o,
    output logic                frame_end_o
);

    localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned Sub  = SCAN_DIV >> BRIGHT_W;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DigW-1:0] dig_q, dig_d;
    logic [FrmW-1:0] frame_q, frame_d;
    logic            phase_q, phase_d;
    logic            cnt_last, dig_last;
    logic [31:0]     cnt_ext;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            dig_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
        end
    end

    assign cnt_last    = (cnt_q == CntW'(SCAN_DIV - 1));
    assign dig_last    = (dig_q == DigW'(NUM_DIGITS - 1));
    assign frame_end_o = cnt_last && dig_last;

    always_comb begin
        cnt_d   = cnt_last ? '0 : cnt_q + CntW'(1);
        dig_d   = dig_q;
        frame_d = frame_q;
        phase_d = phase_q;
        if (cnt_last) begin
            dig_d = dig_last ? '0 : dig_q + DigW'(1);
        end
        // Phase only flips on a frame boundary, so a blink never cuts a frame.
        if (frame_end_o) begin
            if (frame_q == FrmW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FrmW'(1);
            end
        end
    end

    assign cnt_ext = 32'(cnt_q);
    assign sub_o   = BRIGHT_W'(cnt_ext / Sub);
    assign cnt_o   = cnt_q;
    assign dig_o   = dig_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/ssd_scan_n.sv
// Multiplexed N-digit seven-segment driver with PWM brightness, per-digit
// blanking and blinking. All outputs are registered, active-low.
module ssd_scan_n import ssd_pkg::*; #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = ScanDivDefault,
    parameter int unsigned BRIGHT_W     = 3,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SegW*NUM_DIGITS-1:0] seg_in,
    input  logic [NUM_DIGITS-1:0]      dp_in,
    input  logic [NUM_DIGITS-1:0]      blank_in,
    input  logic [NUM_DIGITS-1:0]      blink_in,
    input  logic [BRIGHT_W-1:0]        brightness,
    output logic                       a_out,
    output logic                       b_out,
    output logic                       c_out,
    output logic                       d_out,
    output logic                       e_out,
    output logic                       f_out,
    output logic                       g_out,
    output logic                       p_out,
    output logic [NUM_DIGITS-1:0]      an,
    output logic                       frame_start
);

    localparam int unsigned CntW = $clog2(SCAN_DIV);
    localparam int unsigned DigW = $clog2(NUM_DIGITS);

    if ((SCAN_DIV % (2 ** BRIGHT_W)) != 0) begin : g_bad_scan_div
        $error("SCAN_DIV must be a multiple of 2**BRIGHT_W");
    end

    logic [CntW-1:0]       cnt;
    logic [DigW-1:0]       dig;
    logic [BRIGHT_W-1:0]   sub;
    logic                  phase;
    logic                  frame_end;

    logic [BRIGHT_W-1:0]   br_q, br_eff;
    logic                  lit;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    seg_t                  seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_start_q;
    logic                  scan_first_q;

    ssd_scan_timer #(
        .NUM_DIGITS   (NUM_DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BRIGHT_W     (BRIGHT_W),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .clk_i       (clk),
        .rst_i       (rst),
        .cnt_o       (cnt),
        .dig_o       (dig),
        .sub_o       (sub),
        .phase_o     (phase),
        .frame_end_o (frame_end)
    );

    // Slot start uses the live code so the new value governs the whole slot.
    assign br_eff = (cnt == '0) ? brightness : br_q;

    always_comb begin
        lit   = (sub <= br_eff) && !blank_in[dig] && !(blink_in[dig] && phase);
        an_d  = {NUM_DIGITS{~AnOn}};
        seg_d = {SegW{~SegOn}};
        dp_d  = ~SegOn;
        if (lit) begin
            an_d[dig] = AnOn;
            seg_d     = seg_in[SegW*dig +: SegW];
            dp_d      = dp_in[dig] ? SegOn : ~SegOn;
        end
    end

    // scan_first_q marks the cnt==0/dig==0 cycle: right after reset or a frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_q          <= '0;
            an_q          <= {NUM_DIGITS{~AnOn}};
            seg_q         <= {SegW{~SegOn}};
            dp_q          <= ~SegOn;
            frame_start_q <= 1'b0;
            scan_first_q  <= 1'b1;
        end else begin
            if (cnt == '0) begin
                br_q <= brightness;
            end
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= scan_first_q;
            scan_first_q  <= frame_end;
        end
    end

    assign a_out       = seg_q[SegIdxA];
    assign b_out       = seg_q[SegIdxB];
    assign c_out       = seg_q[SegIdxC];
    assign d_out       = seg_q[SegIdxD];
    assign e_out       = seg_q[SegIdxE];
    assign f_out       = seg_q[SegIdxF];
    assign g_out       = seg_q[SegIdxG];
    assign p_out       = dp_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ssd_scan_n.sv
// Scoreboard bench for ssd_scan_n: a cycle-count reference model predicts each
// registered output; a monitor compares every cycle.
module tb_ssd_scan_n;

    localparam int ND  = 4;
    localparam int SD  = 8;
    localparam int BW  = 2;
    localparam int BF  = 2;
    localparam int SUB = SD / (2 ** BW);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7*ND-1:0] seg_in = '1;
    logic [ND-1:0]   dp_in = '0, blank_in = '0, blink_in = '0;
    logic [BW-1:0]   brightness = '0;
    logic a_out, b_out, c_out, d_out, e_out, f_out, g_out, p_out, frame_start;
    logic [ND-1:0]   an;

    always #5 clk = ~clk;

    ssd_scan_n #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BRIGHT_W     (BW),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .blink_in    (blink_in),
        .brightness  (brightness),
        .a_out       (a_out),
        .b_out       (b_out),
        .c_out       (c_out),
        .d_out       (d_out),
        .e_out       (e_out),
        .f_out       (f_out),
        .g_out       (g_out),
        .p_out       (p_out),
        .an          (an),
        .frame_start (frame_start)
    );

    typedef struct packed {
        logic [ND-1:0] an;
        logic [6:0]    seg;
        logic          dp;
        logic          fs;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model state: cycles since reset release and slot brightness.
    int   n_m = 0;
    int   br_m = 0;

    logic [7*ND-1:0] seg_s;
    logic [ND-1:0]   dp_s, blank_s, blink_s;
    logic [BW-1:0]   br_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input logic r);
        exp_t e;
        int   cnt, dig, ph;
        bit   lit;
        @(negedge clk);
        rst        = r;
        seg_in     = seg_s;
        dp_in      = dp_s;
        blank_in   = blank_s;
        blink_in   = blink_s;
        brightness = br_s;
        e.an  = '1;
        e.seg = '1;
        e.dp  = 1'b1;
        e.fs  = 1'b0;
        if (r) begin
            n_m = 0;
        end else begin
            cnt = n_m % SD;
            dig = (n_m / SD) % ND;
            ph  = ((n_m / (SD * ND)) / BF) % 2;
            if (cnt == 0) br_m = int'(br_s);
            lit = ((cnt / SUB) <= br_m) && !blank_s[dig] && !(blink_s[dig] && ph == 1);
            if (lit) begin
                e.an[dig] = 1'b0;
                e.seg     = seg_s[7*dig +: 7];
                e.dp      = ~dp_s[dig];
            end
            e.fs = (cnt == 0 && dig == 0);
            n_m++;
        end
        exp_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("an", 32'(an), 32'(mon_e.an));
                chk("seg", 32'({a_out, b_out, c_out, d_out, e_out, f_out, g_out}),
                    32'(mon_e.seg));
                chk("dp", 32'(p_out), 32'(mon_e.dp));
                chk("frame_start", 32'(frame_start), 32'(mon_e.fs));
                chk("an_onehot", 32'($countones(~an) <= 1), 32'(1));
            end
        end
    end

    initial begin
        seg_s   = {7'h06, 7'h12, 7'h4F, 7'h01};
        dp_s    = 4'b0010;
        blank_s = '0;
        blink_s = '0;
        br_s    = 2'd3;
        repeat (3) tick(1'b1);
        repeat (64) tick(1'b0);
        br_s = 2'd1;
        repeat (64) tick(1'b0);
        br_s = 2'd0;
        repeat (64) tick(1'b0);
        // Brightness drop in the middle of a slot.
        br_s = 2'd3;
        while (n_m % SD != 3) tick(1'b0);
        br_s = 2'd0;
        repeat (16) tick(1'b0);
        // Blank digit 2, blink digit 0, from a frame-aligned start.
        br_s = 2'd3;
        tick(1'b1);
        blank_s = 4'b0100;
        blink_s = 4'b0001;
        repeat (6 * SD * ND) tick(1'b0);
        // Single-cycle reset at dig=2, cnt=5.
        blank_s = '0;
        blink_s = '0;
        while (!((n_m % SD) == 5 && ((n_m / SD) % ND) == 2)) tick(1'b0);
        tick(1'b1);
        repeat (40) tick(1'b0);
        for (int i = 0; i < 1000; i++) begin
            seg_s   = (7*ND)'($urandom());
            dp_s    = ND'($urandom());
            blank_s = ND'($urandom());
            if ($urandom_range(0, 7) == 0) blink_s = ND'($urandom());
            br_s    = BW'($urandom());
            tick($urandom_range(0, 99) == 0);
        end
        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
